// File: rtl/can_rx_frame_buffer_if.sv
`default_nettype none
// ==== can_rx_frame_buffer_if : CAN RX byte stream in, whole-frame handshake out ====
// ==== Revision 1.0                                                             ====
interface can_rx_frame_buffer_if #(
  parameter int FIFO_AW = 4,
  parameter int DROP_W  = 16
);
  logic                 in_valid;
  logic                 in_last;
  logic [7:0]           in_data;
  logic [28:0]          in_id;
  logic                 in_ide;
  logic                 out_valid;
  logic                 out_ready;
  logic [28:0]          out_id;
  logic                 out_ide;
  logic [3:0]           out_len;
  logic [63:0]          out_data;
  logic [FIFO_AW:0]     level;
  logic                 overflow;
  logic [DROP_W-1:0]    drop_cnt;

  modport master (
    output in_valid, in_last, in_data, in_id, in_ide, out_ready,
    input  out_valid, out_id, out_ide, out_len, out_data, level, overflow, drop_cnt
  );

  modport slave (
    input  in_valid, in_last, in_data, in_id, in_ide, out_ready,
    output out_valid, out_id, out_ide, out_len, out_data, level, overflow, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/can_rx_frame_buffer.sv
`default_nettype none
// ==== can_rx_frame_buffer : reassembles CAN RX bytes into frames, buffers them in a show-ahead FIFO ====
// ==== Revision 1.0                                                                                ====
module can_rx_frame_buffer #(
  parameter int FIFO_AW = 4,
  parameter int DROP_W  = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  can_rx_frame_buffer_if.slave bus
);
  localparam int c_depth = 1 << FIFO_AW;
  localparam int c_ent_w = 29 + 1 + 4 + 64;

  typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t               r_state;
  logic [28:0]          r_id;
  logic                 r_ide;
  logic [3:0]           r_cnt;
  logic [63:0]          r_data;
  logic [FIFO_AW:0]     r_wr_ptr;
  logic [FIFO_AW:0]     r_rd_ptr;
  logic [c_ent_w-1:0]   r_mem [c_depth];
  logic                 r_out_valid;
  logic [28:0]          r_out_id;
  logic                 r_out_ide;
  logic [3:0]           r_out_len;
  logic [63:0]          r_out_data;
  logic                 r_overflow;
  logic [DROP_W-1:0]    r_drop_cnt;

  logic [28:0]          w_id;
  logic                 w_ide;
  logic [3:0]           w_cnt;
  logic [63:0]          w_data;
  logic                 w_commit;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_pop;
  logic [FIFO_AW:0]     w_rd_next;

  // Frame as it would stand once the byte on the bus is merged in.
  always_comb begin
    w_id   = r_id;
    w_ide  = r_ide;
    w_cnt  = r_cnt;
    w_data = r_data;
    if (r_state == IDLE) begin
      w_id   = bus.in_id;
      w_ide  = bus.in_ide;
      w_cnt  = 4'd1;
      w_data = {bus.in_data, 56'd0};
    end else if (r_cnt < 4'd8) begin
      for (int i = 1; i < 8; i++) begin
        if (r_cnt == 4'(i)) w_data[63-8*i -: 8] = bus.in_data;
      end
      w_cnt = r_cnt + 4'd1;
    end
  end

  // Full is judged on pre-pop occupancy, so a same-cycle pop never rescues a frame.
  assign w_commit  = bus.in_valid & bus.in_last;
  assign w_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_wr      = w_commit & ~w_full;
  assign w_pop     = r_out_valid & bus.out_ready;
  assign w_rd_next = w_pop ? r_rd_ptr + (FIFO_AW+1)'(1) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {w_id, w_ide, w_cnt, w_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_id        <= '0;
      r_ide       <= 1'b0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_ide   <= 1'b0;
      r_out_len   <= '0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (bus.in_valid) begin
        r_id    <= w_id;
        r_ide   <= w_ide;
        r_cnt   <= w_cnt;
        r_data  <= w_data;
        r_state <= bus.in_last ? IDLE : COLLECT;
      end
      r_overflow <= w_commit & w_full;
      if (w_commit && w_full && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      if (w_wr) r_wr_ptr <= r_wr_ptr + (FIFO_AW+1)'(1);
      r_rd_ptr <= w_rd_next;
      // Head register reloads every cycle; a frame written this edge shows up one edge later.
      r_out_valid <= (w_rd_next != r_wr_ptr);
      {r_out_id, r_out_ide, r_out_len, r_out_data} <= r_mem[w_rd_next[FIFO_AW-1:0]];
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_id    = r_out_id;
  assign bus.out_ide   = r_out_ide;
  assign bus.out_len   = r_out_len;
  assign bus.out_data  = r_out_data;
  assign bus.level     = r_wr_ptr - r_rd_ptr;
  assign bus.overflow  = r_overflow;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule
`default_nettype wire
